// File: rtl/cpu_defs_pkg.sv
// Core datapath types shared across the pipeline: machine word, register
// address, decoded instruction control bits and the writeback entry.
package cpu_defs_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  typedef struct packed {
    logic regwrite;
    logic hiwrite;
    logic lowrite;
  } control_t;

  typedef struct packed {
    logic [5:0] op;
    control_t   ctl;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t instr;
    creg_addr_t     writereg;
    word_t          result;
    word_t          hi;
    word_t          lo;
  } writeback_data_t;
endpackage

// File: rtl/writeback_pkg.sv
// Writeback-stage arbitration constants and grant encoding.
package writeback_pkg;
  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } wb_grant_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Two writeback producers (main pipe A, mul/div unit B) with valid/ready
// handshakes into the writeback arbiter.
interface wb_arbiter_if;
  import cpu_defs_pkg::*;

  logic            a_valid;
  writeback_data_t a_data;
  logic            a_ready;
  logic            b_valid;
  writeback_data_t b_data;
  logic            b_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/wb_grant_ctrl.sv
// Grant selection between pipes A and B with a bounded starvation counter for A
// and a write-after-write override that keeps the older B entry first.
module wb_grant_ctrl
  import cpu_defs_pkg::*, writeback_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic       b_valid,
  input  creg_addr_t a_writereg,
  input  creg_addr_t b_writereg,
  output wb_grant_t  grant
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          waw_hazard;

  always_comb begin
    waw_hazard = (a_writereg == b_writereg) && (b_writereg != '0);
    grant      = GRANT_NONE;
    // Grants are suppressed during reset so no handshake can complete.
    if (!reset) begin
      if (a_valid && b_valid) begin
        grant = ((starve_q == STARVE_LIMIT) && !waw_hazard) ? GRANT_A : GRANT_B;
      end else if (a_valid) begin
        grant = GRANT_A;
      end else if (b_valid) begin
        grant = GRANT_B;
      end
    end

    starve_d = '0;
    if (a_valid && (grant != GRANT_A)) begin
      starve_d = (starve_q == STARVE_LIMIT) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of two producers per cycle and registers the
// winning entry onto the regfile and HI/LO write ports one cycle later.
module wb_arbiter
  import cpu_defs_pkg::*, writeback_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  wb_arbiter_if.slave       wb,
  output logic              rf_we,
  output creg_addr_t        rf_waddr,
  output word_t             rf_wdata,
  output logic              hi_we,
  output logic              lo_we,
  output word_t             hi_wdata,
  output word_t             lo_wdata,
  output logic [31:0]       retire_cnt
);
  wb_grant_t       grant;
  writeback_data_t sel;
  logic            granted;

  logic        rf_we_q, rf_we_d;
  logic        hi_we_q, hi_we_d;
  logic        lo_we_q, lo_we_d;
  creg_addr_t  rf_waddr_q, rf_waddr_d;
  word_t       rf_wdata_q, rf_wdata_d;
  word_t       hi_wdata_q, hi_wdata_d;
  word_t       lo_wdata_q, lo_wdata_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  wb_grant_ctrl #(.STARVE_MAX(STARVE_MAX)) u_grant_ctrl (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (wb.a_valid),
    .b_valid    (wb.b_valid),
    .a_writereg (wb.a_data.writereg),
    .b_writereg (wb.b_data.writereg),
    .grant      (grant)
  );

  assign wb.a_ready = (grant == GRANT_A);
  assign wb.b_ready = (grant == GRANT_B);

  always_comb begin
    sel          = (grant == GRANT_A) ? wb.a_data : wb.b_data;
    granted      = (grant != GRANT_NONE);
    // Register 0 is hardwired, so a write to it is dropped but still retires.
    rf_we_d      = granted && sel.instr.ctl.regwrite && (sel.writereg != '0);
    hi_we_d      = granted && sel.instr.ctl.hiwrite;
    lo_we_d      = granted && sel.instr.ctl.lowrite;
    rf_waddr_d   = granted ? sel.writereg : rf_waddr_q;
    rf_wdata_d   = granted ? sel.result   : rf_wdata_q;
    hi_wdata_d   = granted ? sel.hi       : hi_wdata_q;
    lo_wdata_d   = granted ? sel.lo       : lo_wdata_q;
    retire_cnt_d = retire_cnt_q + 32'(granted);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q      <= 1'b0;
      hi_we_q      <= 1'b0;
      lo_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      hi_wdata_q   <= '0;
      lo_wdata_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      hi_we_q      <= hi_we_d;
      lo_we_q      <= lo_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      hi_wdata_q   <= hi_wdata_d;
      lo_wdata_q   <= lo_wdata_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign hi_we      = hi_we_q;
  assign lo_we      = lo_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign hi_wdata   = hi_wdata_q;
  assign lo_wdata   = lo_wdata_q;
  assign retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_wb_arbiter;
  import cpu_defs_pkg::*;
  import writeback_pkg::*;

  localparam int SM = 4;

  typedef struct {
    logic        granted;
    logic        rf_we;
    logic        hi_we;
    logic        lo_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we, hi_we, lo_we;
  creg_addr_t  rf_waddr;
  word_t       rf_wdata, hi_wdata, lo_wdata;
  logic [31:0] retire_cnt;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb         (bus),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  exp_t        q[$];
  int          denied  = 0;   // consecutive cycles A has waited while valid
  logic [31:0] cnt_m   = '0;  // grants since reset
  int          last_g  = 0;   // 0 none, 1 A, 2 B
  int          txn     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic writeback_data_t mk(input logic rw, input logic hw, input logic lw,
                                         input logic [4:0] wreg, input logic [31:0] res,
                                         input logic [31:0] hi, input logic [31:0] lo);
    writeback_data_t e;
    e.instr.op           = 6'h0;
    e.instr.ctl.regwrite = rw;
    e.instr.ctl.hiwrite  = hw;
    e.instr.ctl.lowrite  = lw;
    e.writereg           = wreg;
    e.result             = res;
    e.hi                 = hi;
    e.lo                 = lo;
    return e;
  endfunction

  function automatic writeback_data_t rand_entry();
    return mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom);
  endfunction

  // Arbitration rules: single requester wins; with both, B wins unless A has
  // waited STARVE_MAX cycles, and B always wins on a same-register collision.
  function automatic int model_grant();
    if (bus.a_valid && bus.b_valid) begin
      if ((bus.a_data.writereg == bus.b_data.writereg) && (bus.b_data.writereg != 5'd0))
        return 2;
      return (denied >= SM) ? 1 : 2;
    end
    if (bus.a_valid) return 1;
    if (bus.b_valid) return 2;
    return 0;
  endfunction

  // One clock: inputs already driven at the falling edge.
  task automatic step();
    exp_t            e;
    writeback_data_t s;
    int              g;
    #1;
    g = model_grant();
    check("a_ready", {31'd0, bus.a_ready}, {31'd0, g == 1});
    check("b_ready", {31'd0, bus.b_ready}, {31'd0, g == 2});
    e = '{granted: 1'b0, rf_we: 1'b0, hi_we: 1'b0, lo_we: 1'b0,
          waddr: 5'd0, wdata: 32'd0, hi: 32'd0, lo: 32'd0, cnt: 32'd0};
    if (g != 0) begin
      s         = (g == 1) ? bus.a_data : bus.b_data;
      cnt_m     = cnt_m + 32'd1;
      e.granted = 1'b1;
      e.rf_we   = s.instr.ctl.regwrite && (s.writereg != 5'd0);
      e.hi_we   = s.instr.ctl.hiwrite;
      e.lo_we   = s.instr.ctl.lowrite;
      e.waddr   = s.writereg;
      e.wdata   = s.result;
      e.hi      = s.hi;
      e.lo      = s.lo;
    end
    e.cnt = cnt_m;
    q.push_back(e);
    if (bus.a_valid && g != 1) denied = (denied >= SM) ? SM : denied + 1;
    else                       denied = 0;
    last_g = g;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rf_we", {31'd0, rf_we}, {31'd0, e.rf_we});
      check("hi_we", {31'd0, hi_we}, {31'd0, e.hi_we});
      check("lo_we", {31'd0, lo_we}, {31'd0, e.lo_we});
      if (e.granted) begin
        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
        check("rf_wdata", rf_wdata, e.wdata);
        check("hi_wdata", hi_wdata, e.hi);
        check("lo_wdata", lo_wdata, e.lo);
        txn++;
        $display("txn %0d: rf_we=%0b waddr=%0d wdata=%h hi_we=%0b lo_we=%0b retire=%0d",
                 txn, rf_we, rf_waddr, rf_wdata, hi_we, lo_we, retire_cnt);
      end
      check("retire_cnt", retire_cnt, e.cnt);
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    q.delete();
    denied = 0;
    cnt_m  = '0;
    last_g = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_data  = mk(0, 0, 0, 0, 0, 0, 0);
    bus.b_data  = mk(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.a_valid = 1'b1;  // a request held during reset must not be granted
    #1;
    check("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    bus.a_valid = 1'b0;
    apply_reset();

    // Single A write to r5.
    bus.a_valid = 1'b1;
    bus.a_data  = mk(1, 0, 0, 5'd5, 32'h1234, 0, 0);
    step();
    check("d_rf_we", {31'd0, rf_we}, 32'd1);
    check("d_waddr", {27'd0, rf_waddr}, 32'd5);
    check("d_wdata", rf_wdata, 32'h1234);
    check("d_retire", retire_cnt, 32'd1);

    // HI/LO only from B.
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1;
    bus.b_data  = mk(0, 1, 1, 5'd3, 32'h9, 32'hAAAA0000, 32'h5555);
    step();
    check("hl_hi_we", {31'd0, hi_we}, 32'd1);
    check("hl_lo_we", {31'd0, lo_we}, 32'd1);
    check("hl_rf_we", {31'd0, rf_we}, 32'd0);
    check("hl_hi", hi_wdata, 32'hAAAA0000);
    check("hl_lo", lo_wdata, 32'h5555);

    // Write to r0 is dropped but still retires.
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_data  = mk(1, 0, 0, 5'd0, 32'hDEAD, 0, 0);
    step();
    check("r0_rf_we", {31'd0, rf_we}, 32'd0);
    check("r0_retire", retire_cnt, 32'd3);

    // Continuous contention: B four times, then A, repeating.
    bus.a_data  = mk(1, 0, 0, 5'd1, 32'h11, 0, 0);
    bus.b_valid = 1'b1;
    bus.b_data  = mk(1, 0, 0, 5'd2, 32'h22, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("starve_a", {31'd0, bus.a_ready}, {31'd0, (i % 5) == 4});
      step();
    end

    // Starved A still loses to B on a same-register collision.
    for (int i = 0; i < 4; i++) step();
    bus.a_data.writereg = 5'd7;
    bus.b_data.writereg = 5'd7;
    #1;
    check("waw_b_ready", {31'd0, bus.b_ready}, 32'd1);
    check("waw_a_ready", {31'd0, bus.a_ready}, 32'd0);
    step();
    bus.b_valid = 1'b0;
    step();

    // Randomized traffic; producers hold entries until accepted.
    for (int i = 0; i < 300; i++) begin
      if (!bus.a_valid || last_g == 1) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_data  = rand_entry();
      end
      if (!bus.b_valid || last_g == 2) begin
        bus.b_valid = ($urandom_range(0, 3) != 0);
        bus.b_data  = rand_entry();
      end
      step();
    end

    // Reset mid-stream with a registered grant.
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_data  = mk(1, 0, 0, 5'd9, 32'h77, 0, 0);
    step();
    check("mid_rf_we_pre", {31'd0, rf_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rf_we", {31'd0, rf_we}, 32'd0);
    check("mid_retire", retire_cnt, 32'd0);
    check("mid_a_ready", {31'd0, bus.a_ready}, 32'd0);
    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 20; i++) begin
      if (!bus.a_valid || last_g == 1) begin
        bus.a_valid = ($urandom_range(0, 1) != 0);
        bus.a_data  = rand_entry();
      end
      if (!bus.b_valid || last_g == 2) begin
        bus.b_valid = ($urandom_range(0, 1) != 0);
        bus.b_data  = rand_entry();
      end
      step();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
